// File: rtl/dpram_master.sv
// Load/store initiator for one port of the 32-bit dual-port RAM: byte/half/word at any
// byte address, misaligned accesses split over two RAM cycles, load data extended.
module dpram_master #(
  parameter int RAM_DEPTH = 2048,
  // Bit width needed to hold RAM_DEPTH-1
  parameter int AW        = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_L = AW1'(RAM_DEPTH);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAITR, RESP} state_t;

  state_t state_reg, state_next;

  logic          we_reg;
  logic          uns_reg;
  logic [1:0]    size_reg;
  logic [1:0]    off_reg;
  logic [AW-1:0] idx_reg;
  logic          split_reg;
  logic [7:0]    mask_reg;
  logic [63:0]   wd64_reg;
  logic [31:0]   lo_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          rsp_err_reg;

  // Request decode, only meaningful while IDLE
  logic [1:0]    req_off;
  logic [AW-1:0] req_idx;
  logic [7:0]    base_mask;
  logic [7:0]    req_mask;
  logic          req_split;
  logic [AW:0]   req_idx_inc;
  logic          req_err;
  logic [63:0]   req_wd64;

  assign req_off     = req_addr[1:0];
  assign req_idx     = req_addr[AW+1:2];
  assign base_mask   = (req_size == 2'd0) ? 8'h01 : (req_size == 2'd1) ? 8'h03 : 8'h0F;
  assign req_mask    = base_mask << req_off;
  assign req_split   = |req_mask[7:4];
  assign req_idx_inc = {1'b0, req_idx} + AW1'(1);
  assign req_wd64    = {32'b0, req_wdata} << {req_off, 3'b000};
  assign req_err     = (req_size == 2'd3)
                    || (|req_addr[31:AW+2])
                    || ({1'b0, req_idx} >= DEPTH_L)
                    || (req_split && (req_idx_inc >= DEPTH_L));

  // Load alignment: split loads pair the held low word with the word now on ram_dout
  logic [63:0] rd_word64;
  logic [5:0]  rd_base;
  logic [31:0] rd_aligned;
  logic [31:0] rd_ext;

  assign rd_word64 = split_reg ? {ram_dout, lo_reg} : {32'b0, ram_dout};
  assign rd_base   = {off_reg, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_aligned[8*gi +: 8] = rd_word64[rd_base + 6'(8*gi) +: 8];
    end
  endgenerate

  always_comb begin
    rd_ext = rd_aligned;
    case (size_reg)
      2'd0:    rd_ext = uns_reg ? {24'b0, rd_aligned[7:0]}
                                : {{24{rd_aligned[7]}}, rd_aligned[7:0]};
      2'd1:    rd_ext = uns_reg ? {16'b0, rd_aligned[15:0]}
                                : {{16{rd_aligned[15]}}, rd_aligned[15:0]};
      default: rd_ext = rd_aligned;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_wem    = 4'b0;
    ram_addr   = '0;
    ram_din    = 32'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_err ? RESP : ACC0;
      end
      ACC0: begin
        ram_en   = 1'b1;
        ram_we   = we_reg;
        ram_addr = idx_reg;
        if (we_reg) begin
          ram_wem = mask_reg[3:0];
          ram_din = wd64_reg[31:0];
        end
        if (split_reg)   state_next = ACC1;
        else if (we_reg) state_next = RESP;
        else             state_next = WAITR;
      end
      ACC1: begin
        ram_en   = 1'b1;
        ram_we   = we_reg;
        ram_addr = idx_reg + AW'(1);
        if (we_reg) begin
          ram_wem = mask_reg[7:4];
          ram_din = wd64_reg[63:32];
        end
        state_next = we_reg ? RESP : WAITR;
      end
      WAITR: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg        <= 1'b0;
      uns_reg       <= 1'b0;
      size_reg      <= 2'b0;
      off_reg       <= 2'b0;
      idx_reg       <= '0;
      split_reg     <= 1'b0;
      mask_reg      <= 8'b0;
      wd64_reg      <= 64'b0;
      lo_reg        <= 32'b0;
      rsp_rdata_reg <= 32'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            uns_reg       <= req_unsigned;
            size_reg      <= req_size;
            off_reg       <= req_off;
            idx_reg       <= req_idx;
            split_reg     <= req_split;
            mask_reg      <= req_mask;
            wd64_reg      <= req_wd64;
            rsp_err_reg   <= req_err;
            rsp_rdata_reg <= 32'b0;
          end
        end
        ACC1: begin
          if (!we_reg) lo_reg <= ram_dout;
        end
        WAITR: rsp_rdata_reg <= rd_ext;
        RESP: begin
          if (rsp_ready) begin
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dpram_master.sv
// Bench for dpram_master: behavioural RAM on the port, byte-level reference memory,
// directed literal checks plus randomized traffic compared on every response cycle.
module tb_dpram_master;
  localparam int RAM_DEPTH = 2048;
  localparam int AW        = 11;
  localparam int NBYTES    = RAM_DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0]   req_addr = 32'b0, req_wdata = 32'b0;
  logic [1:0]    req_size = 2'b0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          ram_en, ram_we;
  logic [3:0]    ram_wem;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;

  dpram_master #(.RAM_DEPTH(RAM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Simple model of one dpram port, with a preload path used before traffic starts
  logic [31:0]   mem [0:RAM_DEPTH-1];
  logic          init_en = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [31:0]   init_data = 32'b0;

  always @(posedge clk) begin
    if (init_en) mem[init_addr] <= init_data;
    else if (ram_en) begin
      if (ram_we) begin
        for (int i = 0; i < 4; i++)
          if (ram_wem[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      end else ram_dout <= mem[ram_addr];
    end
  end

  logic [7:0] ref_mem [0:NBYTES-1];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nram;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_x = 0;

  logic [31:0] cap_addr [0:1];
  logic [31:0] cap_wem  [0:1];
  logic [31:0] cap_din  [0:1];
  int          cap_n = 0;
  bit          in_rsp = 0;
  logic [31:0] last_rdata = 32'b0;
  logic        last_err = 1'b0;
  int          last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: what a request must return, applied to a flat byte memory
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata);
    exp_t        e;
    int          nb;
    bit          split;
    logic [31:0] v;
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.err   = 1'b0;
    e.rdata = 32'b0;
    if (size == 2'd3 || longint'(addr) + longint'(nb) > longint'(NBYTES)) begin
      e.err  = 1'b1;
      e.lat  = 1;
      e.nram = 0;
      return e;
    end
    split  = (int'(addr[1:0]) + nb) > 4;
    e.nram = split ? 2 : 1;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      e.lat = split ? 3 : 2;
    end else begin
      v = 32'b0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
      if (!uns && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
      e.lat   = split ? 4 : 3;
    end
    return e;
  endfunction

  // Compare process: every response cycle is checked against the queued expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      exp_q.delete();
      in_rsp = 0;
      cap_n  = 0;
    end else begin
      if (ram_en) begin
        if (cap_n < 2) begin
          cap_addr[cap_n] = 32'(ram_addr);
          cap_wem[cap_n]  = 32'(ram_wem);
          cap_din[cap_n]  = ram_din;
        end
        cap_n++;
      end
      if (rsp_valid) begin
        chk("rsp_req_ready_low", 32'(req_ready), 32'd0);
        chk("rsp_ram_en_low", 32'(ram_en), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
        end else begin
          if (!in_rsp) begin
            in_rsp   = 1;
            last_lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
            chk("rsp_latency", 32'(last_lat), 32'(exp_q[0].lat));
            chk("rsp_ram_cycles", 32'(cap_n), 32'(exp_q[0].nram));
          end
          chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            void'(exp_q.pop_front());
            in_rsp = 0;
          end
        end
      end
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        cap_n = 0;
      end
    end
  end

  // Called and returns at posedge+1
  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input int hold, input bit junk);
    int t;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(we, addr, size, uns, wdata));
    @(posedge clk); #1;
    if (junk && hold > 0) begin
      req_we = 1'($urandom); req_addr = $urandom_range(0, 255); req_size = 2'd2;
    end else req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 for 20 cycles, expected 1");
    end
    repeat (hold) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_x++;
    $display("xact %0d: we=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
             n_x, we, addr, size, uns, wdata, last_rdata, last_err, last_lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
    chk({tag, "_ram_en"},    32'(ram_en),    32'd0);
    chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
    chk({tag, "_ram_wem"},   32'(ram_wem),   32'd0);
    chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_ram_din"},   ram_din,        32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [1:0]  sz;
    int          bad;
    #1;
    init_en = 1'b1;
    for (int w = 0; w < RAM_DEPTH; w++) begin
      d = $urandom;
      init_addr = w[AW-1:0];
      init_data = d;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = d[8*b +: 8];
      @(posedge clk); #1;
    end
    init_en = 1'b0;
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_released");

    // Aligned word store and load
    xact(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0);
    chk("st_w_addr", cap_addr[0], 32'h40);
    chk("st_w_wem", cap_wem[0], 32'hF);
    chk("st_w_lat", 32'(last_lat), 32'd2);
    chk("st_w_err", 32'(last_err), 32'd0);
    xact(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 0);
    chk("ld_w_rdata", last_rdata, 32'hDEADBEEF);
    chk("ld_w_lat", 32'(last_lat), 32'd3);

    // Byte store, signed/unsigned byte loads, halfword over the stored byte
    xact(1'b1, 32'h103, 2'd0, 1'b0, 32'h000000A5, 0, 0);
    chk("st_b_wem", cap_wem[0], 32'h8);
    chk("st_b_din", cap_din[0], 32'hA5000000);
    xact(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 0, 0);
    chk("ld_b_signed", last_rdata, 32'hFFFFFFA5);
    xact(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 0, 0);
    chk("ld_b_unsigned", last_rdata, 32'h000000A5);
    xact(1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 0, 0);
    chk("ld_h_signed", last_rdata, 32'hFFFFA5AD);

    // Misaligned word store and load across words 0x7F/0x80
    xact(1'b1, 32'h1FE, 2'd2, 1'b0, 32'h11223344, 0, 0);
    chk("st_split_addr0", cap_addr[0], 32'h7F);
    chk("st_split_wem0", cap_wem[0], 32'hC);
    chk("st_split_din0", cap_din[0], 32'h33440000);
    chk("st_split_addr1", cap_addr[1], 32'h80);
    chk("st_split_wem1", cap_wem[1], 32'h3);
    chk("st_split_din1", cap_din[1], 32'h00001122);
    chk("st_split_lat", 32'(last_lat), 32'd3);
    xact(1'b0, 32'h1FE, 2'd2, 1'b0, 32'h0, 0, 0);
    chk("ld_split_rdata", last_rdata, 32'h11223344);
    chk("ld_split_lat", 32'(last_lat), 32'd4);

    // Errors: out of range, spanning past the last word, illegal size
    xact(1'b0, 32'h2000, 2'd2, 1'b0, 32'h0, 0, 0);
    chk("err_range_err", 32'(last_err), 32'd1);
    chk("err_range_lat", 32'(last_lat), 32'd1);
    xact(1'b1, 32'h1FFE, 2'd2, 1'b0, 32'hCAFEF00D, 0, 0);
    chk("err_span_err", 32'(last_err), 32'd1);
    chk("err_span_rdata", last_rdata, 32'd0);
    xact(1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 0, 0);
    chk("err_size3_err", 32'(last_err), 32'd1);

    // Response backpressure with a competing request held on the channel
    xact(1'b0, 32'h1FE, 2'd2, 1'b0, 32'h0, 5, 1);
    chk("bp_rdata", last_rdata, 32'h11223344);
    chk("bp_idle_after", 32'(req_ready), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      case ($urandom % 8)
        0, 1, 2, 3: a = 32'h100 + $urandom_range(0, 31);
        4, 5:       a = 32'h1FC0 + $urandom_range(0, 67);
        6:          a = 32'h1F0 + $urandom_range(0, 31);
        default:    a = $urandom;
      endcase
      sz = (($urandom % 16) == 0) ? 2'd3 : 2'($urandom % 3);
      xact(1'($urandom), a, sz, 1'($urandom), $urandom,
           (($urandom % 4) == 0) ? int'($urandom_range(1, 4)) : 0, 1'($urandom));
    end

    // Reset during the second half of a split store
    xact(1'b1, 32'h1FC, 2'd2, 1'b0, 32'h01020304, 0, 0);
    xact(1'b1, 32'h200, 2'd2, 1'b0, 32'h05060708, 0, 0);
    req_we = 1'b1; req_addr = 32'h1FE; req_size = 2'd2; req_unsigned = 1'b0;
    req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_acc0_addr", 32'(ram_addr), 32'h7F);
    @(posedge clk); #1;
    chk("rst_mid_acc1_addr", 32'(ram_addr), 32'h80);
    chk("rst_mid_acc1_wem", 32'(ram_wem), 32'h3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    ref_mem[32'h1FE] = 8'hDD;
    ref_mem[32'h1FF] = 8'hCC;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h1FC, 2'd2, 1'b0, 32'h0, 0, 0);
    chk("rst_mid_word7f", last_rdata, 32'hCCDD0304);
    xact(1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 0, 0);
    chk("rst_mid_word80", last_rdata, 32'h05060708);

    // Whole RAM against the reference byte memory
    bad = 0;
    for (int w = 0; w < RAM_DEPTH; w++)
      for (int b = 0; b < 4; b++)
        if (mem[w][8*b +: 8] !== ref_mem[4*w + b]) begin
          if (bad == 0) $display("first differing byte at %h", 4*w + b);
          bad++;
        end
    chk("mem_final_bad_bytes", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
